pia_config_loader: RTL
======================

# pia_config_loader

Serial configuration loader feeding the PIA-to-LAB routing fabric. It deserialises a framed, checksummed bitstream into a shadow register. On a valid frame it commits the shadow into the active routing configuration bus that drives each LAB's `lab_router` `configuration` input. A corrupt or aborted frame never disturbs the active configuration.

## Interface
- `num_labs`, default 2: number of LABs served; the active bus holds one routing word per LAB.
- `pia_to_lab_routing_bit_count`, default 144: routing bits per LAB; must be a multiple of 8.
- `clock`, input, 1: sole clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `frame_start`, input, 1: one-cycle pulse that begins a new frame.
- `bit_in`, input, 1: serial data bit.
- `bit_valid`, input, 1: `bit_in` is consumed on a rising edge where this is high and the state is SHIFT.
- `configuration`, output, `num_labs*pia_to_lab_routing_bit_count`: active routing bus; LAB k owns bits [k*144 +: 144].
- `busy`, output, 1: high in SHIFT, CHECK and COMMIT.
- `commit_pulse`, output, 1: one-cycle pulse when the active bus is updated.
- `loaded`, output, 1: high after the first successful commit since reset.
- `checksum_error`, output, 1: sticky; set by a failed frame, cleared by `frame_start` or reset.

## Operation
- Define N = `num_labs*pia_to_lab_routing_bit_count`, which is 288 at the defaults.
- A frame is N payload bits, LSB first, where payload bit i goes to shadow bit i. It is followed by an 8-bit checksum, LSB first.
- The checksum is the bytewise XOR of the payload. Byte j is payload bits [8j+7:8j]. Running accumulator: `acc[i mod 8] ^= bit` for each payload bit.
- States: IDLE, SHIFT, CHECK, COMMIT.
- IDLE → SHIFT on `frame_start`. Entry clears the bit counter, the accumulator and `checksum_error`. The shadow is not cleared.
- In SHIFT, each accepted bit increments the counter. The counter width is clog2(N+8).
  - Counter < N: the bit is written to the shadow and XORed into the accumulator.
  - Counter in N..N+7: the bit is XORed into the accumulator at position counter−N.
  - Accepting bit N+7 moves the state to CHECK.
- CHECK lasts one cycle.
  - Accumulator == 0: go to COMMIT.
  - Otherwise: set `checksum_error` and go to IDLE.
- COMMIT lasts one cycle. It copies shadow to `configuration`, pulses `commit_pulse`, sets `loaded`, then goes to IDLE.
- `frame_start` while in SHIFT aborts the current frame and restarts SHIFT, with the same clearing as the IDLE → SHIFT entry. `checksum_error` is not set by an abort.
- `frame_start` during CHECK or COMMIT is ignored; the frame completes normally.
- `bit_valid` outside SHIFT is ignored.
- Gaps, where `bit_valid` is low during SHIFT, are unlimited; there is no timeout.
- If `frame_start` and `bit_valid` are high on the same cycle, `frame_start` wins and that bit is discarded.

## Timing
- Reset values:
  - `configuration` = all zeros.
  - `busy`, `commit_pulse`, `loaded`, `checksum_error` = 0.
  - State IDLE; counter and accumulator 0.
- Reset mid-frame discards the frame and also zeroes the active `configuration`.
- `busy` rises on the cycle after `frame_start` is sampled.
- Latency from the edge accepting the final checksum bit:
  - Edge +1: CHECK.
  - Edge +2: `configuration` updated and `commit_pulse` high, valid for exactly one cycle.
  - Edge +3: `busy` low.
- On a failed frame, `checksum_error` is high from edge +2; `busy` is low at edge +2.
- Minimum frame duration is N+8 accepting cycles, plus 2 cycles, plus 1 `frame_start` cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared Verilog include `max7000_config_defs.v` holds:
  - State encodings: IDLE=2'd0, SHIFT=2'd1, CHECK=2'd2, COMMIT=2'd3.
  - The checksum width (8).
  - The default routing bit count (144), also used by `lab_router`.
- Sub-module `config_checksum` is the 8-bit XOR accumulator.
  - Inputs: clock, reset, clear, bit, bit_valid, position[2:0].
  - Output: acc[7:0].
- The top level holds the FSM, the bit counter, the shadow register and the active register.

## Test plan
- **Good frame:** reset, then a 288-bit payload of alternating bytes 0xA5/0x5A, with checksum 0x00 (18 pairs). Required: `configuration` shows that pattern, `commit_pulse` is high for 1 cycle at final edge +2, and `loaded` = 1.
- **Bad checksum:** payload all 0xFF bytes with correct checksum 0x00, but bit 3 of the checksum flipped (sent as 0x08). Required: `checksum_error` = 1, `configuration` holds its prior value, no `commit_pulse`.
- **Abort:** after 100 bits, assert `frame_start`, then send a full good frame with LAB0 = 0x01 repeated and LAB1 = 0x00. Required: a single commit reflecting only the second frame, and `checksum_error` = 0.
- **Gaps:** a good frame with `bit_valid` toggling at random (~50%), and with `bit_in` garbage on invalid cycles. Required: a result identical to the gap-free case.
- **Reset mid-frame:** commit pattern P, start a new frame, assert `reset` at bit 150. Required: `configuration` = 0, `loaded` = 0, state IDLE, and a following good frame commits correctly.
- **Collisions:**
  - `frame_start` together with `bit_valid` on the first cycle: the bit is discarded and the counter stays 0.
  - `frame_start` during CHECK: ignored, and the commit still happens.

Source files
------------

// File: rtl/pia_config_loader_pkg.sv
// rtl/pia_config_loader_pkg.sv - shared state encodings and widths for the PIA configuration loader
// Purpose: FSM state type, checksum width and default per-LAB routing width,
// shared by the loader top level and the lab_router that consumes its bus.
package pia_config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int CHECKSUM_WIDTH            = 8;
  localparam int DEFAULT_ROUTING_BIT_COUNT = 144;

endpackage

// File: rtl/config_checksum.sv
// rtl/config_checksum.sv - serial bytewise XOR checksum accumulator
// Purpose: folds each accepted serial bit into acc[position]; after a payload
// and its checksum byte have been folded in, acc is zero for an intact frame.
// Ports:
//   clock, reset       - clock and synchronous active-high reset
//   clear              - zero the accumulator (wins over bit_valid)
//   bit_in, bit_valid  - serial bit and its qualifier
//   position[2:0]      - accumulator bit the incoming bit is XORed into
//   acc[7:0]           - running accumulator
module config_checksum
  import pia_config_loader_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  input  logic [2:0]                position,
  output logic [CHECKSUM_WIDTH-1:0] acc
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (bit_valid) begin
      acc[position] <= acc[position] ^ bit_in;
    end
  end

endmodule

// File: rtl/pia_config_loader.sv
// rtl/pia_config_loader.sv - framed, checksummed serial loader for the PIA-to-LAB routing bus
// Purpose: shifts N payload bits (LSB first) into a shadow register followed
// by an 8-bit bytewise-XOR checksum; an intact frame is committed to the active
// configuration bus, a corrupt or aborted one leaves it untouched.
// Ports:
//   clock, reset             - clock and synchronous active-high reset
//   frame_start              - pulse that starts (or restarts) a frame
//   bit_in, bit_valid        - serial data and qualifier, consumed in SHIFT
//   configuration            - active routing bus, LAB k owns [k*bits +: bits]
//   busy                     - frame in progress (SHIFT, CHECK or COMMIT)
//   commit_pulse             - high for the single cycle the bus is updated
//   loaded                   - a frame has committed since reset
//   checksum_error           - sticky failed-frame flag, cleared by frame_start
module pia_config_loader
  import pia_config_loader_pkg::*;
#(
  parameter int num_labs                     = 2,
  parameter int pia_to_lab_routing_bit_count = DEFAULT_ROUTING_BIT_COUNT
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             frame_start,
  input  logic                                             bit_in,
  input  logic                                             bit_valid,
  output logic [num_labs*pia_to_lab_routing_bit_count-1:0] configuration,
  output logic                                             busy,
  output logic                                             commit_pulse,
  output logic                                             loaded,
  output logic                                             checksum_error
);

  localparam int N  = num_labs * pia_to_lab_routing_bit_count;
  localparam int CW = $clog2(N + CHECKSUM_WIDTH);

  state_t                      state, next_state;
  logic [CW-1:0]               counter;
  logic [N-1:0]                shadow;
  logic [CHECKSUM_WIDTH-1:0]   acc;

  // frame_start only acts in IDLE/SHIFT; in CHECK/COMMIT the frame runs out.
  logic start, accept, in_payload, last_bit, checksum_ok;
  assign start       = frame_start && (state == IDLE || state == SHIFT);
  assign accept      = (state == SHIFT) && bit_valid && !frame_start;
  assign in_payload  = counter < CW'(N);
  assign last_bit    = counter == CW'(N + CHECKSUM_WIDTH - 1);
  assign checksum_ok = (acc == '0);

  // N is a multiple of 8, so counter mod 8 equals both the payload byte lane
  // and (counter - N) for the checksum byte.
  config_checksum u_checksum (
    .clock    (clock),
    .reset    (reset),
    .clear    (start),
    .bit_in   (bit_in),
    .bit_valid(accept),
    .position (counter[2:0]),
    .acc      (acc)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT: begin
        if (start) next_state = SHIFT;
        else if (accept && last_bit) next_state = CHECK;
      end
      CHECK:   next_state = checksum_ok ? COMMIT : IDLE;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      configuration  <= '0;
      commit_pulse   <= 1'b0;
      loaded         <= 1'b0;
      checksum_error <= 1'b0;
    end else begin
      state <= next_state;
      if (start) begin
        counter        <= '0;
        checksum_error <= 1'b0;
      end else if (accept) begin
        counter <= counter + 1'b1;
      end
      if (state == CHECK && !checksum_ok) checksum_error <= 1'b1;
      // Commit outputs are registered on entry to COMMIT so they are valid
      // for exactly the COMMIT cycle.
      commit_pulse <= (state == CHECK) && checksum_ok;
      if (state == CHECK && checksum_ok) begin
        configuration <= shadow;
        loaded        <= 1'b1;
      end
    end
  end

  // Shadow is deliberately not reset: only a checked frame reaches the bus.
  always_ff @(posedge clock) begin
    if (accept && in_payload) shadow[counter] <= bit_in;
  end

  assign busy = (state != IDLE);

endmodule
